// File: rtl/mem_io_ctrl_if.sv
// CPU-side request/ready bus between the SLC-3 MAR/MDR
// and the memory/IO controller.
interface mem_io_ctrl_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_io_ctrl.sv
// Memory/IO controller: fixed-latency RAM plus one
// switch/hex IO register, with a request/ready handshake.
module mem_io_ctrl #(
  parameter int          RAM_LATENCY = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic          Clk,
  input  logic          Reset,
  mem_io_ctrl_if.slave  bus,
  output logic [15:0]   ram_addr,
  output logic [15:0]   ram_din,
  output logic          ram_en,
  output logic          ram_we,
  input  logic [15:0]   ram_dout,
  input  logic [15:0]   S,
  output logic [15:0]   hex_data
);

  typedef enum logic [2:0] {
    IDLE,
    RAM_RD,
    RAM_WR,
    RESP,
    HOLD
  } state_t;

  state_t      state;
  state_t      next;
  logic [2:0]  cnt;
  logic [15:0] s_meta;
  logic [15:0] s_sync;
  logic [15:0] rdata;
  logic        ready;

  logic        req;
  logic        is_io;
  logic        io_wr;
  logic        io_rd;
  logic        ram_go;
  logic        rd_done;

  assign req   = bus.mem_rd | bus.mem_wr;
  assign is_io = (bus.mem_addr == IO_ADDR);

  assign bus.mem_rdata = rdata;
  assign bus.mem_ready = ready;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      s_meta <= '0;
      s_sync <= '0;
    end else begin
      s_meta <= S;
      s_sync <= s_meta;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (is_io)           next = RESP;
          else if (bus.mem_wr) next = RAM_WR;
          else                 next = RAM_RD;
        end
      end
      RAM_RD:  if (cnt == 3'd0) next = RESP;
      RAM_WR:  next = RESP;
      RESP:    next = HOLD;
      HOLD:    if (!req) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Write wins over read when both request levels are high.
  always_comb begin
    io_wr  = 1'b0;
    io_rd  = 1'b0;
    ram_go = 1'b0;
    if (state == IDLE && req) begin
      unique case (1'b1)
        (is_io && bus.mem_wr):  io_wr  = 1'b1;
        (is_io && !bus.mem_wr): io_rd  = 1'b1;
        (!is_io):               ram_go = 1'b1;
      endcase
    end
    rd_done = (state == RAM_RD) && (cnt == 3'd0);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ram_addr <= '0;
      ram_din  <= '0;
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      cnt      <= '0;
      rdata    <= '0;
      hex_data <= '0;
      ready    <= 1'b0;
    end else begin
      ram_en <= ram_go;
      ram_we <= ram_go & bus.mem_wr;
      ready  <= (next == RESP);
      if (ram_go) begin
        ram_addr <= bus.mem_addr;
        cnt      <= 3'(RAM_LATENCY);
      end
      if (ram_go && bus.mem_wr) ram_din <= bus.mem_wdata;
      if (state == RAM_RD && cnt != 3'd0) cnt <= cnt - 3'd1;
      if (io_wr)   hex_data <= bus.mem_wdata;
      if (io_rd)   rdata    <= s_sync;
      if (rd_done) rdata    <= ram_dout;
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl with a fixed-latency
// RAM model and a queue of expected completions.
module tb_mem_io_ctrl;
  localparam int LAT = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] ram_addr;
  logic [15:0] ram_din;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_dout;
  logic [15:0] S = 16'h0000;
  logic [15:0] hex_data;

  mem_io_ctrl_if bus ();

  mem_io_ctrl #(
    .RAM_LATENCY(LAT),
    .IO_ADDR(16'hFFFF)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus),
    .ram_addr(ram_addr),
    .ram_din(ram_din),
    .ram_en(ram_en),
    .ram_we(ram_we),
    .ram_dout(ram_dout),
    .S(S),
    .hex_data(hex_data)
  );

  always #5 Clk = ~Clk;

  logic [15:0] ram [0:65535];
  logic [15:0] pipe [0:LAT-1];

  assign ram_dout = pipe[LAT-1];

  always @(posedge Clk) begin
    if (ram_en && ram_we) ram[ram_addr] <= ram_din;
    pipe[0] <= (ram_en && !ram_we) ? ram[ram_addr] : 16'hDEAD;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  typedef struct {
    int          n;
    logic [15:0] rdata;
    logic [15:0] hex;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic rd, input logic wr,
                     input logic [15:0] addr,
                     input logic [15:0] wdata,
                     input int n,
                     input logic [15:0] exp_rd,
                     input logic [15:0] exp_hex,
                     input int exp_en);
    exp_t e;
    int c;
    int en_cnt;
    int extra;
    @(negedge Clk);
    bus.mem_rd    = rd;
    bus.mem_wr    = wr;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    e.n = n;
    e.rdata = exp_rd;
    e.hex = exp_hex;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    c = 1;
    en_cnt = 0;
    while (1) begin
      if (ram_en) begin
        en_cnt++;
        check("ram_addr", ram_addr, addr);
        check("ram_we", ram_we, wr);
        if (wr) check("ram_din", ram_din, wdata);
      end
      if (bus.mem_ready || c >= 20) break;
      @(posedge Clk);
      #1;
      c++;
    end
    check("mem_ready", bus.mem_ready, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("latency", c, e.n);
      check("mem_rdata", bus.mem_rdata, e.rdata);
      check("hex_data", hex_data, e.hex);
      check("ram_en_cnt", en_cnt, exp_en);
    end
    // Keep the request held; a second access must not start.
    extra = 0;
    repeat (5) begin
      @(posedge Clk);
      #1;
      if (bus.mem_ready || ram_en) extra++;
    end
    check("one_access", extra, 0);
    @(negedge Clk);
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    repeat (2) @(posedge Clk);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
    for (int i = 0; i < LAT; i++) pipe[i] = 16'h0000;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 16'h0000;

    Reset = 1'b0;
    S = 16'h1234;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_rdata", bus.mem_rdata, 0);
    check("rst_ready", bus.mem_ready, 0);
    check("rst_hex", hex_data, 0);
    check("rst_ram_bus", {ram_addr, ram_din}, 0);
    check("rst_en_we", {ram_en, ram_we}, 0);

    @(negedge Clk);
    Reset = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(posedge Clk);
      #1;
      if (ram_en || bus.mem_ready) cnt++;
    end
    check("idle_quiet", cnt, 0);

    S = 16'h0003;
    repeat (3) @(posedge Clk);
    req(1, 0, 16'hFFFF, 16'h0000, 1, 16'h0003, 16'h0000, 0);
    S = 16'h0001;
    repeat (3) @(posedge Clk);
    req(1, 0, 16'hFFFF, 16'h0000, 1, 16'h0001, 16'h0000, 0);
    req(0, 1, 16'hFFFF, 16'h00A5, 1, 16'h0001, 16'h00A5, 0);
    req(0, 1, 16'h0010, 16'hBEEF, 2, 16'h0001, 16'h00A5, 1);
    req(1, 0, 16'h0010, 16'h0000, LAT + 2, 16'hBEEF, 16'h00A5, 1);
    req(0, 1, 16'h0000, 16'h1111, 2, 16'hBEEF, 16'h00A5, 1);
    req(0, 1, 16'hFFFE, 16'h2222, 2, 16'hBEEF, 16'h00A5, 1);
    req(1, 0, 16'hFFFE, 16'h0000, LAT + 2, 16'h2222, 16'h00A5, 1);
    req(1, 0, 16'h0000, 16'h0000, LAT + 2, 16'h1111, 16'h00A5, 1);
    req(1, 1, 16'hFFFF, 16'h5A5A, 1, 16'h1111, 16'h5A5A, 0);

    // Reset lands in cycle 2 of a RAM read.
    @(negedge Clk);
    bus.mem_rd   = 1'b1;
    bus.mem_addr = 16'h0010;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    bus.mem_rd = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(posedge Clk);
      #1;
      if (bus.mem_ready) cnt++;
    end
    check("abort_no_ready", cnt, 0);
    check("abort_rdata", bus.mem_rdata, 0);
    check("abort_hex", hex_data, 0);

    S = 16'h0077;
    repeat (3) @(posedge Clk);
    req(1, 0, 16'hFFFF, 16'h0000, 1, 16'h0077, 16'h0000, 0);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
